// File: rtl/phase_shift_calc_mc_if.sv
// Bus between the LLRF control sequencer (master) and the multi-channel
// phase-shift calculator (slave).
//   start            per-channel calculation request
//   freq             per-channel phase increment per tick, ch c at [c*PW +: PW]
//   current_phase    per-channel phase now
//   desired_phase    per-channel target phase at time_from_start
//   time_from_start  per-channel ticks until target, ch c at [c*TW +: TW]
//   ramp_ticks       per-channel ramp length, ch c at [c*RW +: RW]
//   phase_shift      per-channel signed shift result
//   phase_step       per-channel signed per-tick ramp step
//   ready            per-channel result valid
//   busy             engine not idle
//   done / done_ch   one-cycle write pulse and the channel written
interface phase_shift_calc_mc_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned PW   = 32,
    parameter int unsigned TW   = 32,
    parameter int unsigned RW   = 16
);
    localparam int unsigned CHW = $clog2(N_CH);

    logic [N_CH-1:0]    start;
    logic [N_CH*PW-1:0] freq;
    logic [N_CH*PW-1:0] current_phase;
    logic [N_CH*PW-1:0] desired_phase;
    logic [N_CH*TW-1:0] time_from_start;
    logic [N_CH*RW-1:0] ramp_ticks;
    logic [N_CH*PW-1:0] phase_shift;
    logic [N_CH*PW-1:0] phase_step;
    logic [N_CH-1:0]    ready;
    logic               busy;
    logic               done;
    logic [CHW-1:0]     done_ch;

    modport master (
        output start, freq, current_phase, desired_phase, time_from_start, ramp_ticks,
        input  phase_shift, phase_step, ready, busy, done, done_ch
    );

    modport slave (
        input  start, freq, current_phase, desired_phase, time_from_start, ramp_ticks,
        output phase_shift, phase_step, ready, busy, done, done_ch
    );
endinterface

// File: rtl/phase_shift_calc_mc.sv
// Multi-channel phase-shift calculator. A single round-robin arbitrated
// engine computes, per channel, shift = desired - (current + freq*time)
// mod 2^PW and a signed ramp step shift/ramp_ticks (truncated toward zero).
// Ports: clk, reset (async, active-high), ifc (slave side of the bus).
module phase_shift_calc_mc #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned PW   = 32,
    parameter int unsigned TW   = 32,
    parameter int unsigned RW   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    phase_shift_calc_mc_if.slave  ifc
);
    localparam int unsigned CHW  = $clog2(N_CH);
    localparam int unsigned CNTW = $clog2(PW);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_ADD, S_SUB, S_DIV, S_WRITE
    } state_t;

    state_t          state;
    logic [N_CH-1:0] pending;
    logic [CHW-1:0]  rr_ptr;
    logic [CHW-1:0]  ch;
    logic [PW-1:0]   prod_lo;
    logic [PW-1:0]   future;
    logic [PW-1:0]   shift;
    logic [PW-1:0]   dvd;      // dividend shifting out, quotient shifting in
    logic [RW-1:0]   rem;
    logic            neg;
    logic            bypass;
    logic [CNTW-1:0] cnt;

    // Operands of the channel currently in the engine
    logic [PW-1:0] sel_freq, sel_cur, sel_des;
    logic [TW-1:0] sel_time;
    logic [RW-1:0] sel_ramp;

    always_comb begin
        sel_freq = '0;
        sel_cur  = '0;
        sel_des  = '0;
        sel_time = '0;
        sel_ramp = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (ch == CHW'(c)) begin
                sel_freq = ifc.freq[c*PW +: PW];
                sel_cur  = ifc.current_phase[c*PW +: PW];
                sel_des  = ifc.desired_phase[c*PW +: PW];
                sel_time = ifc.time_from_start[c*TW +: TW];
                sel_ramp = ifc.ramp_ticks[c*RW +: RW];
            end
        end
    end

    // Round-robin grant: first pending channel at or after rr_ptr, cyclically
    logic           grant_vld_c;
    logic [CHW-1:0] grant_ch_c;
    int             off;
    int             best_off;

    always_comb begin
        grant_vld_c = 1'b0;
        grant_ch_c  = '0;
        best_off    = int'(N_CH);
        off         = 0;
        for (int c = 0; c < int'(N_CH); c++) begin
            off = (c + int'(N_CH) - int'(rr_ptr)) % int'(N_CH);
            if (pending[c] && (off < best_off)) begin
                best_off    = off;
                grant_vld_c = 1'b1;
                grant_ch_c  = CHW'(c);
            end
        end
    end

    // Signed shift and its magnitude; -2^(PW-1) maps onto itself as unsigned
    logic [PW-1:0] shift_c, abs_c;
    assign shift_c = sel_des - future;
    assign abs_c   = shift_c[PW-1] ? (PW'(0) - shift_c) : shift_c;

    // One restoring-division step; the true remainder always fits in RW bits
    logic [RW:0]   rem_sh_c;
    logic          fits_c;
    logic [RW-1:0] rem_sub_c;
    assign rem_sh_c  = {rem, dvd[PW-1]};
    assign fits_c    = rem_sh_c[RW] | (rem_sh_c[RW-1:0] >= sel_ramp);
    assign rem_sub_c = rem_sh_c[RW-1:0] - sel_ramp;

    logic [PW-1:0] step_c;
    assign step_c = bypass ? shift : (neg ? (PW'(0) - dvd) : dvd);

    // Engine FSM, arbitration and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            pending         <= '0;
            rr_ptr          <= '0;
            ch              <= '0;
            prod_lo         <= '0;
            future          <= '0;
            shift           <= '0;
            dvd             <= '0;
            rem             <= '0;
            neg             <= 1'b0;
            bypass          <= 1'b0;
            cnt             <= '0;
            ifc.phase_shift <= '0;
            ifc.phase_step  <= '0;
            ifc.ready       <= '0;
            ifc.busy        <= 1'b0;
            ifc.done        <= 1'b0;
            ifc.done_ch     <= '0;
        end else begin
            pending   <= pending | ifc.start;
            ifc.ready <= ifc.ready & ~ifc.start;
            ifc.done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld_c) begin
                        ch       <= grant_ch_c;
                        rr_ptr   <= (grant_ch_c == CHW'(N_CH - 1)) ? '0 : grant_ch_c + CHW'(1);
                        pending  <= (pending & ~(N_CH'(1) << grant_ch_c)) | ifc.start;
                        ifc.busy <= 1'b1;
                        state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Only the low PW bits of the full product are kept, and
                    // they depend only on the low PW bits of each operand.
                    prod_lo <= sel_freq * PW'(sel_time);
                    state   <= S_ADD;
                end
                S_ADD: begin
                    future <= sel_cur + prod_lo;
                    state  <= S_SUB;
                end
                S_SUB: begin
                    shift  <= shift_c;
                    neg    <= shift_c[PW-1];
                    dvd    <= abs_c;
                    rem    <= '0;
                    cnt    <= '0;
                    bypass <= (sel_ramp < RW'(2));
                    state  <= S_DIV;
                end
                S_DIV: begin
                    if (bypass) begin
                        state <= S_WRITE;
                    end else begin
                        rem <= fits_c ? rem_sub_c : rem_sh_c[RW-1:0];
                        dvd <= {dvd[PW-2:0], fits_c};
                        cnt <= cnt + CNTW'(1);
                        if (cnt == CNTW'(PW - 1)) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // A result is stale if the channel was re-requested meanwhile
                    for (int c = 0; c < int'(N_CH); c++) begin
                        if (ch == CHW'(c)) begin
                            ifc.phase_shift[c*PW +: PW] <= shift;
                            ifc.phase_step[c*PW +: PW]  <= step_c;
                            ifc.ready[c]                <= ~(ifc.start[c] | pending[c]);
                        end
                    end
                    ifc.done    <= 1'b1;
                    ifc.done_ch <= ch;
                    ifc.busy    <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    ifc.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_phase_shift_calc_mc.sv
// Testbench for phase_shift_calc_mc: table of single-channel jobs with
// hand-computed results and latencies, then round-robin ordering,
// re-request during division, and reset during division.
module tb_phase_shift_calc_mc;
    localparam int unsigned N_CH = 4;
    localparam int unsigned PW   = 32;
    localparam int unsigned TW   = 32;
    localparam int unsigned RW   = 16;

    logic clk;
    logic reset;

    phase_shift_calc_mc_if #(.N_CH(N_CH), .PW(PW), .TW(TW), .RW(RW)) bus ();

    phase_shift_calc_mc #(.N_CH(N_CH), .PW(PW), .TW(TW), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel views of the packed buses
    logic [PW-1:0] f_a   [N_CH];
    logic [TW-1:0] t_a   [N_CH];
    logic [PW-1:0] cur_a [N_CH];
    logic [PW-1:0] des_a [N_CH];
    logic [RW-1:0] r_a   [N_CH];
    logic [PW-1:0] sh_a  [N_CH];
    logic [PW-1:0] st_a  [N_CH];

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        assign bus.freq[g*PW +: PW]            = f_a[g];
        assign bus.time_from_start[g*TW +: TW] = t_a[g];
        assign bus.current_phase[g*PW +: PW]   = cur_a[g];
        assign bus.desired_phase[g*PW +: PW]   = des_a[g];
        assign bus.ramp_ticks[g*RW +: RW]      = r_a[g];
        assign sh_a[g] = bus.phase_shift[g*PW +: PW];
        assign st_a[g] = bus.phase_step[g*PW +: PW];
    end

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] f;
        logic [31:0] t;
        logic [31:0] cur;
        logic [31:0] des;
        logic [15:0] ramp;
        logic [31:0] exp_shift;
        logic [31:0] exp_step;
        int          lat;
    } vec_t;

    vec_t vecs [10];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_ch(input logic [1:0] c, input logic [31:0] f, input logic [31:0] t,
                          input logic [31:0] cur, input logic [31:0] des, input logic [15:0] ramp);
        f_a[c]   = f;
        t_a[c]   = t;
        cur_a[c] = cur;
        des_a[c] = des;
        r_a[c]   = ramp;
    endtask

    task automatic wait_done(input string name, output logic [1:0] c, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < 200);
        if (bus.done !== 1'b1) begin
            n_total++;
            $display("FAIL %s: no done within %0d cycles", name, n);
        end
        c = bus.done_ch;
    endtask

    initial begin
        logic [1:0] c;
        int         n;
        int         dcount;
        logic [3:0] rseen;

        vecs[0] = '{2'd0, 32'h0147AE14, 32'd200, 32'hC0000000, 32'h0,        16'd16,    32'h40000060, 32'h04000006, 37};
        vecs[1] = '{2'd1, 32'h0,        32'd0,   32'hC0000000, 32'h80000000, 16'd3,     32'hC0000000, 32'hEAAAAAAB, 37};
        vecs[2] = '{2'd1, 32'h0,        32'd0,   32'hC0000000, 32'h80000000, 16'd4,     32'hC0000000, 32'hF0000000, 37};
        vecs[3] = '{2'd2, 32'h0,        32'd0,   32'h0,        32'h80000000, 16'd2,     32'h80000000, 32'hC0000000, 37};
        vecs[4] = '{2'd2, 32'h0,        32'd0,   32'h0,        32'h80000000, 16'd0,     32'h80000000, 32'h80000000, 6};
        vecs[5] = '{2'd2, 32'h0,        32'd0,   32'h0,        32'h80000000, 16'd1,     32'h80000000, 32'h80000000, 6};
        vecs[6] = '{2'd3, 32'h0,        32'd0,   32'h0,        32'h00000007, 16'd2,     32'h00000007, 32'h00000003, 37};
        vecs[7] = '{2'd0, 32'h0,        32'd0,   32'h0,        32'h00000064, 16'd5,     32'h00000064, 32'h00000014, 37};
        vecs[8] = '{2'd3, 32'h0,        32'd0,   32'h0,        32'hFFFFFFF9, 16'd2,     32'hFFFFFFF9, 32'hFFFFFFFD, 37};
        vecs[9] = '{2'd3, 32'h80000000, 32'd3,   32'h80000000, 32'h00000010, 16'hFFFF,  32'h00000010, 32'h00000000, 37};

        reset     = 1'b1;
        bus.start = '0;
        for (int i = 0; i < int'(N_CH); i++) set_ch(2'(i), '0, '0, '0, '0, '0);
        tick();
        tick();

        chk("reset phase_shift", 64'(bus.phase_shift[63:0]), 64'h0);
        chk("reset phase_step",  64'(bus.phase_step[63:0]),  64'h0);
        chk("reset ready",       64'(bus.ready),   64'h0);
        chk("reset busy",        64'(bus.busy),    64'h0);
        chk("reset done",        64'(bus.done),    64'h0);
        chk("reset done_ch",     64'(bus.done_ch), 64'h0);
        reset = 1'b0;
        tick();

        // Single-channel jobs
        for (int i = 0; i < 10; i++) begin
            set_ch(vecs[i].ch, vecs[i].f, vecs[i].t, vecs[i].cur, vecs[i].des, vecs[i].ramp);
            bus.start = 4'b0001 << vecs[i].ch;
            tick();
            bus.start = '0;
            chk($sformatf("vec%0d ready cleared", i), 64'(bus.ready[vecs[i].ch]), 64'h0);
            wait_done($sformatf("vec%0d", i), c, n);
            chk($sformatf("vec%0d latency", i),   64'(n), 64'(vecs[i].lat));
            chk($sformatf("vec%0d done_ch", i),   64'(c), 64'(vecs[i].ch));
            chk($sformatf("vec%0d shift", i),     64'(sh_a[vecs[i].ch]), 64'(vecs[i].exp_shift));
            chk($sformatf("vec%0d step", i),      64'(st_a[vecs[i].ch]), 64'(vecs[i].exp_step));
            chk($sformatf("vec%0d ready", i),     64'(bus.ready[vecs[i].ch]), 64'h1);
            chk($sformatf("vec%0d busy idle", i), 64'(bus.busy), 64'h0);
            tick();
            chk($sformatf("vec%0d done pulse", i), 64'(bus.done), 64'h0);
        end

        // Unwritten channels keep their last results
        chk("hold shift ch0", 64'(sh_a[0]), 64'h00000064);
        chk("hold step ch0",  64'(st_a[0]), 64'h00000014);
        chk("hold shift ch1", 64'(sh_a[1]), 64'hC0000000);
        chk("hold step ch1",  64'(st_a[1]), 64'hF0000000);
        chk("hold step ch2",  64'(st_a[2]), 64'h80000000);
        chk("hold ready",     64'(bus.ready), 64'hF);

        // Round robin from rr_ptr=0, then ch0/ch1 re-requested while ch3 runs
        for (int i = 0; i < int'(N_CH); i++) set_ch(2'(i), '0, '0, '0, 32'(i + 1), 16'd0);
        bus.start = 4'b1111;
        tick();
        bus.start = '0;
        chk("rr ready cleared", 64'(bus.ready), 64'h0);
        wait_done("rr 1st", c, n);
        chk("rr order 1st", 64'(c), 64'd0);
        wait_done("rr 2nd", c, n);
        chk("rr order 2nd", 64'(c), 64'd1);
        wait_done("rr 3rd", c, n);
        chk("rr order 3rd", 64'(c), 64'd2);
        tick();
        bus.start = 4'b0011;
        tick();
        bus.start = '0;
        wait_done("rr 4th", c, n);
        chk("rr order 4th", 64'(c), 64'd3);
        wait_done("rr 5th", c, n);
        chk("rr order 5th", 64'(c), 64'd0);
        wait_done("rr 6th", c, n);
        chk("rr order 6th", 64'(c), 64'd1);
        chk("rr shift ch2", 64'(sh_a[2]), 64'h3);
        chk("rr step ch3",  64'(st_a[3]), 64'h4);
        chk("rr ready",     64'(bus.ready), 64'hF);

        // Re-request of ch2 during its own division
        set_ch(2'd2, '0, '0, '0, 32'h00000100, 16'd2);
        bus.start = 4'b0100;
        tick();
        bus.start = '0;
        repeat (10) tick();
        bus.start = 4'b0100;
        tick();
        bus.start = '0;
        wait_done("restart 1st", c, n);
        chk("restart 1st ch",    64'(c), 64'd2);
        chk("restart 1st ready", 64'(bus.ready[2]), 64'h0);
        wait_done("restart 2nd", c, n);
        chk("restart 2nd ch",    64'(c), 64'd2);
        chk("restart 2nd ready", 64'(bus.ready[2]), 64'h1);
        chk("restart shift",     64'(sh_a[2]), 64'h00000100);
        chk("restart step",      64'(st_a[2]), 64'h00000080);

        // Reset while ch0 is dividing
        set_ch(2'd0, 32'h0147AE14, 32'd200, 32'hC0000000, 32'h0, 16'd16);
        bus.start = 4'b0001;
        tick();
        bus.start = '0;
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        chk("mid reset phase_shift", 64'(bus.phase_shift[127:64] | bus.phase_shift[63:0]), 64'h0);
        chk("mid reset phase_step",  64'(bus.phase_step[127:64] | bus.phase_step[63:0]), 64'h0);
        chk("mid reset ready",       64'(bus.ready), 64'h0);
        chk("mid reset busy",        64'(bus.busy),  64'h0);
        chk("mid reset done_ch",     64'(bus.done_ch), 64'h0);
        tick();
        reset = 1'b0;
        dcount = 0;
        rseen  = '0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.done === 1'b1) dcount++;
            rseen = rseen | bus.ready;
        end
        chk("post reset done count", 64'(dcount), 64'h0);
        chk("post reset ready",      64'(rseen),  64'h0);
        chk("post reset busy",       64'(bus.busy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
